// File: rtl/apb_pkg.sv
// Shared definitions for the two-client APB master: FSM state encoding and
// default bus geometry / timeout constants.
package apb_pkg;

    localparam int APB_ADDR_WIDTH     = 8;
    localparam int APB_DATA_WIDTH     = 32;
    localparam int APB_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } apb_state_t;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin arbiter. The grant is combinational and only produced
// while i_en is high; the last-grant pointer moves only when a grant is made.
// The pointer resets to 1 so that client 0 wins the first tie.
module apb_rr_arbiter (
    input  logic       pclk,
    input  logic       prst,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_gnt,
    output logic       o_gnt_valid
);

    logic       r_last;
    logic [1:0] w_gnt;

    // Grant selection: a lone requester wins, a tie goes to the client not granted last.
    always_comb begin
        w_gnt = 2'b00;
        if (i_en) begin
            if (i_req == 2'b11) begin
                w_gnt = r_last ? 2'b01 : 2'b10;
            end else begin
                w_gnt = i_req;
            end
        end
    end

    assign o_gnt       = w_gnt;
    assign o_gnt_valid = |w_gnt;

    // Last-grant pointer, updated only on an actual grant.
    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            r_last <= 1'b1;
        end else if (w_gnt != 2'b00) begin
            r_last <= w_gnt[1];
        end
    end

endmodule

// File: rtl/apb_arb_master.sv
// Two-requester APB master: round-robin grant between two clients, then a
// SETUP/ACCESS sequence on a single APB slave, with a one-cycle done pulse
// returning read data and the slave error to the winner.
// Optional feature macro: APB_TIMEOUT_EN (aborts ACCESS after TIMEOUT_CYCLES
// wait cycles with err=1 and rdata=0).
//
// Client handshake: a client raises req[i] with we/addr/wdata stable and keeps
// them until done[i] pulses; it must drop req[i] (or present a new request)
// by the edge that ends the DONE cycle. Fields are latched at grant time.
module apb_arb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
    input  logic                    pclk,
    input  logic                    prst,
    input  logic [1:0]              req,
    input  logic [1:0]              we,
    input  logic [2*ADDR_WIDTH-1:0] addr,
    input  logic [2*DATA_WIDTH-1:0] wdata,
    output logic [1:0]              done,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    err,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr,
    output apb_state_t              o_dbg_state
);

    apb_state_t              r_state;
    logic                    r_psel;
    logic                    r_penable;
    logic                    r_pwrite;
    logic [ADDR_WIDTH-1:0]   r_paddr;
    logic [DATA_WIDTH-1:0]   r_pwdata;
    logic [1:0]              r_win_oh;
    logic [1:0]              r_done;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_err;

    logic [1:0]              w_gnt;
    logic                    w_gnt_valid;
    logic                    w_sel_we;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_wdata;

`ifdef APB_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCW-1:0]          r_tcnt;
    logic [TCW-1:0]          w_tcnt_next;
    assign w_tcnt_next = r_tcnt + 1'b1;
`endif

    apb_rr_arbiter u_arb (
        .pclk        (pclk),
        .prst        (prst),
        .i_req       (req),
        .i_en        (r_state == IDLE),
        .o_gnt       (w_gnt),
        .o_gnt_valid (w_gnt_valid)
    );

    // Fields of the granted client; only meaningful while a grant is valid.
    always_comb begin
        w_sel_we    = w_gnt[1] ? we[1] : we[0];
        w_sel_addr  = w_gnt[1] ? addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr[ADDR_WIDTH-1:0];
        w_sel_wdata = w_gnt[1] ? wdata[2*DATA_WIDTH-1:DATA_WIDTH] : wdata[DATA_WIDTH-1:0];
    end

    // Transfer FSM with registered APB control and client response outputs.
    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            r_state   <= IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_win_oh  <= 2'b00;
            r_done    <= 2'b00;
            r_rdata   <= '0;
            r_err     <= 1'b0;
`ifdef APB_TIMEOUT_EN
            r_tcnt    <= '0;
`endif
        end else begin
            r_done <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_win_oh  <= w_gnt;
                        r_pwrite  <= w_sel_we;
                        r_paddr   <= w_sel_addr;
                        r_pwdata  <= w_sel_wdata;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
`ifdef APB_TIMEOUT_EN
                        r_tcnt    <= '0;
`endif
                        r_state   <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_rdata   <= r_pwrite ? '0 : prdata;
                        r_err     <= pslverr;
                        r_done    <= r_win_oh;
                        r_state   <= DONE;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (w_tcnt_next == TCW'(TIMEOUT_CYCLES)) begin
                        r_tcnt    <= w_tcnt_next;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_rdata   <= '0;
                        r_err     <= 1'b1;
                        r_done    <= r_win_oh;
                        r_state   <= DONE;
                    end else begin
                        r_tcnt    <= w_tcnt_next;
                    end
`endif
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign psel        = r_psel;
    assign penable     = r_penable;
    assign pwrite      = r_pwrite;
    assign paddr       = r_paddr;
    assign pwdata      = r_pwdata;
    assign done        = r_done;
    assign rdata       = r_rdata;
    assign err         = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed bench for apb_arb_master with a small APB memory slave model
// (16 words; addresses at or above 16 return pslverr and are not written).
// Build with APB_TIMEOUT_EN defined to also exercise the ACCESS timeout.
`timescale 1ns/1ps
module tb_apb_arb_master;
    import apb_pkg::*;

    localparam int AW        = 8;
    localparam int DW        = 32;
    localparam int TOUT      = 4;
    localparam int MEM_WORDS = 16;

    logic            pclk = 1'b0;
    logic            prst;
    logic [1:0]      req;
    logic [1:0]      we;
    logic [2*AW-1:0] addr;
    logic [2*DW-1:0] wdata;
    logic [1:0]      done;
    logic [DW-1:0]   rdata;
    logic            err;
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pwdata;
    logic [DW-1:0]   prdata;
    logic            pready;
    logic            pslverr;
    apb_state_t      dbg_state;

    int n_assert = 0;
    int n_fail   = 0;

    // Slave model state
    logic [DW-1:0] mem [MEM_WORDS];
    int            slv_wait = 0;
    logic          hold_low = 1'b0;
    int            acc_cnt  = 0;

    always #5 pclk = ~pclk;

    apb_arb_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .pclk        (pclk),
        .prst        (prst),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .done        (done),
        .rdata       (rdata),
        .err         (err),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr),
        .o_dbg_state (dbg_state)
    );

    // APB memory slave: slv_wait low-pready cycles per ACCESS, or stalled by hold_low.
    assign pslverr = psel && penable && (paddr >= AW'(MEM_WORDS));
    assign prdata  = (paddr < AW'(MEM_WORDS)) ? mem[paddr[3:0]] : '0;
    assign pready  = psel && penable && !hold_low && (acc_cnt >= slv_wait);

    always @(posedge pclk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (psel && penable && pready && pwrite && !pslverr)
            mem[paddr[3:0]] <= pwdata;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero_outs(input string tag);
        check({tag, " state"},   64'(dbg_state), 64'(IDLE));
        check({tag, " psel"},    64'(psel),    0);
        check({tag, " penable"}, 64'(penable), 0);
        check({tag, " pwrite"},  64'(pwrite),  0);
        check({tag, " paddr"},   64'(paddr),   0);
        check({tag, " pwdata"},  64'(pwdata),  0);
        check({tag, " done"},    64'(done),    0);
        check({tag, " rdata"},   64'(rdata),   0);
        check({tag, " err"},     64'(err),     0);
    endtask

    // Drive one client request and wait (bounded) for its done pulse.
    task automatic xfer(input int c, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int exp_lat,
                        input logic [DW-1:0] exp_rd, input logic exp_err,
                        input string tag);
        int lat;
        lat = 0;
        @(negedge pclk);
        req[c] = 1'b1;
        we[c]  = w;
        addr[c*AW +: AW]  = a;
        wdata[c*DW +: DW] = d;
        while (done == 2'b00 && lat < 60) begin
            @(negedge pclk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat),    64'(exp_lat));
        check({tag, " done"},    64'(done),   64'(2'b01 << c));
        check({tag, " rdata"},   64'(rdata),  64'(exp_rd));
        check({tag, " err"},     64'(err),    64'(exp_err));
        req[c] = 1'b0;
    endtask

    task automatic reset_pulse();
        @(negedge pclk);
        prst = 1'b0;
        @(negedge pclk);
        prst = 1'b1;
    endtask

    initial begin
        int cyc0, cyc1, setup1, k, guard, bad;
        logic [DW-1:0] rd1;
        logic [1:0]    order [8];
        logic [DW-1:0] rds   [8];

        req = '0; we = '0; addr = '0; wdata = '0;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = '0;
        prst = 1'b0;
        repeat (3) @(negedge pclk);
        check_zero_outs("reset");
        prst = 1'b1;

        // Preload memory through the DUT
        xfer(0, 1'b1, 8'h05, 32'hDEADBEEF, 3, 32'h0, 1'b0, "wr0");
        xfer(1, 1'b1, 8'h06, 32'h12345678, 3, 32'h0, 1'b0, "wr1");
        check("mem5 written", 64'(mem[5]), 64'h DEADBEEF);
        check("mem6 written", 64'(mem[6]), 64'h 12345678);

        // Single read with phase-by-phase checks
        @(negedge pclk);
        req[0] = 1'b1; we[0] = 1'b0; addr[AW-1:0] = 8'h05;
        @(negedge pclk);
        check("rd setup state",   64'(dbg_state), 64'(SETUP));
        check("rd setup psel",    64'(psel),      1);
        check("rd setup penable", 64'(penable),   0);
        check("rd setup paddr",   64'(paddr),     64'h05);
        check("rd setup pwrite",  64'(pwrite),    0);
        @(negedge pclk);
        check("rd access state",   64'(dbg_state), 64'(ACCESS));
        check("rd access penable", 64'(penable),   1);
        @(negedge pclk);
        check("rd done state", 64'(dbg_state), 64'(DONE));
        check("rd done",       64'(done),      64'h1);
        check("rd rdata",      64'(rdata),     64'h DEADBEEF);
        check("rd err",        64'(err),       0);
        check("rd done psel",  64'(psel),      0);
        req[0] = 1'b0;
        @(negedge pclk);
        check("rd idle state",  64'(dbg_state), 64'(IDLE));
        check("rd pulse ends",  64'(done),      0);
        check("rd rdata holds", 64'(rdata),     64'h DEADBEEF);
        check("rd paddr holds", 64'(paddr),     64'h05);

        // Tie after reset: client 0 first, client 1 SETUP at 5, done at 7
        reset_pulse();
        @(negedge pclk);
        req = 2'b11; we = 2'b00;
        addr = {8'h06, 8'h05};
        cyc0 = 0; cyc1 = 0; setup1 = 0; rd1 = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge pclk);
            if (done[0] && cyc0 == 0) begin cyc0 = i; req[0] = 1'b0; end
            if (done[1] && cyc1 == 0) begin cyc1 = i; rd1 = rdata; req[1] = 1'b0; end
            if (dbg_state == SETUP && paddr == 8'h06 && setup1 == 0) setup1 = i;
        end
        check("tie done0 cycle",  64'(cyc0),   3);
        check("tie setup1 cycle", 64'(setup1), 5);
        check("tie done1 cycle",  64'(cyc1),   7);
        check("tie rdata1",       64'(rd1),    64'h 12345678);

        // Fairness: both hold req, grants must alternate starting with 0
        @(negedge pclk);
        req = 2'b11; we = 2'b00;
        addr = {8'h06, 8'h05};
        k = 0; guard = 0;
        while (k < 8 && guard < 80) begin
            @(negedge pclk);
            guard++;
            if (done != 2'b00) begin
                order[k] = done;
                rds[k]   = rdata;
                k++;
            end
        end
        req = 2'b00;
        check("fair count", 64'(k), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("fair grant %0d", i), 64'(order[i]), (i % 2 == 0) ? 64'h1 : 64'h2);
            check($sformatf("fair rdata %0d", i), 64'(rds[i]),
                  (i % 2 == 0) ? 64'h DEADBEEF : 64'h 12345678);
        end

        // Slave error on out-of-range write
        xfer(1, 1'b1, 8'h20, 32'hCAFEF00D, 3, 32'h0, 1'b1, "slverr");
        check("slverr mem0 intact", 64'(mem[0]), 0);
        check("slverr mem5 intact", 64'(mem[5]), 64'h DEADBEEF);

        // Three wait states: done at cycle 6
        slv_wait = 3;
        xfer(1, 1'b0, 8'h06, 32'h0, 6, 32'h12345678, 1'b0, "wait3");
        slv_wait = 0;

        // Reset during ACCESS
        hold_low = 1'b1;
        @(negedge pclk);
        req[0] = 1'b1; we[0] = 1'b0; addr[AW-1:0] = 8'h05;
        guard = 0;
        while (dbg_state != ACCESS && guard < 10) begin
            @(negedge pclk);
            guard++;
        end
        check("rst reach access", 64'(dbg_state), 64'(ACCESS));
        prst = 1'b0;
        #1;
        check_zero_outs("rst mid access");
        req[0] = 1'b0;
        hold_low = 1'b0;
        @(negedge pclk);
        prst = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge pclk);
            if (done != 2'b00) bad++;
        end
        check("rst no done pulse", 64'(bad), 0);
        xfer(1, 1'b0, 8'h05, 32'h0, 3, 32'hDEADBEEF, 1'b0, "post rst");

`ifdef APB_TIMEOUT_EN
        // Timeout: 4 ACCESS cycles with pready low, done at cycle 6
        hold_low = 1'b1;
        xfer(0, 1'b0, 8'h05, 32'h0, 6, 32'h0, 1'b1, "timeout");
        hold_low = 1'b0;
        @(negedge pclk);
        check("timeout idle", 64'(dbg_state), 64'(IDLE));
        check("timeout psel", 64'(psel),      0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
